// File: rtl/pe_out_arb.sv
// pe_out_arb: packet-aware 2:1 output arbiter.
// Two PE result streams are each buffered in a small skid FIFO and merged onto
// one 64-bit output link. Whole packets are granted round-robin and are never
// interleaved. A packet is a header word (LEN in header[LEN_W-1:0]) followed by
// LEN payload words.
//
// Ports:
//   CLK       clock, all logic on posedge
//   SYS_RST   synchronous reset, active-high
//   S0_D      source 0 data word
//   S0_VALID  source 0 word valid (written when FIFO not full)
//   S0_BP     registered almost-full backpressure to source 0
//   S1_D      source 1 data word
//   S1_VALID  source 1 word valid
//   S1_BP     registered almost-full backpressure to source 1
//   Q         merged output data (registered, holds when not valid)
//   Q_VALID   output word valid (registered)
//   Q_BP      downstream backpressure; no word is popped while high
//   BUSY      high while a packet grant is open
//   OVF       sticky per-source overflow flags, cleared only by reset
module pe_out_arb #(
    parameter int FDEPTH   = 16,
    parameter int BP_SLACK = 4,
    parameter int LEN_W    = 16
) (
    input  logic        CLK,
    input  logic        SYS_RST,
    input  logic [63:0] S0_D,
    input  logic        S0_VALID,
    output logic        S0_BP,
    input  logic [63:0] S1_D,
    input  logic        S1_VALID,
    output logic        S1_BP,
    output logic [63:0] Q,
    output logic        Q_VALID,
    input  logic        Q_BP,
    output logic        BUSY,
    output logic [1:0]  OVF
);

    localparam int AW  = $clog2(FDEPTH);
    localparam int AWP = AW + 1;
    localparam logic [AW:0] FULL_LVL = AWP'(FDEPTH);
    localparam logic [AW:0] BP_LVL   = AWP'(FDEPTH - BP_SLACK);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND0 = 2'd1,
        ST_SEND1 = 2'd2
    } state_t;

    // Per-source FIFO storage and pointers (extra MSB distinguishes full from empty)
    logic [63:0]      mem_r   [2][FDEPTH];
    logic [AW:0]      wptr_r  [2];
    logic [AW:0]      rptr_r  [2];
    logic [1:0]       bp_r;
    logic [1:0]       ovf_r;

    logic [63:0]      din_s   [2];
    logic [1:0]       vld_s;
    logic [AW:0]      occ_s   [2];
    logic [AW:0]      occ_nxt_s [2];
    logic [63:0]      rdata_s [2];
    logic [1:0]       full_s;
    logic [1:0]       empty_s;
    logic [1:0]       push_s;
    logic [1:0]       pop_s;
    logic [63:0]      cur_word_s;

    // Arbiter state
    state_t           state_r;
    logic             last_r;
    logic             hdr_done_r;
    logic [LEN_W-1:0] rem_r;
    logic [63:0]      q_r;
    logic             q_valid_r;
    logic             busy_r;

    assign din_s[0] = S0_D;
    assign din_s[1] = S1_D;
    assign vld_s    = {S1_VALID, S0_VALID};

    assign S0_BP   = bp_r[0];
    assign S1_BP   = bp_r[1];
    assign OVF     = ovf_r;
    assign Q       = q_r;
    assign Q_VALID = q_valid_r;
    assign BUSY    = busy_r;

    // FIFO status decode; a push into a full FIFO is refused even when a pop frees a slot
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            occ_s[i]     = wptr_r[i] - rptr_r[i];
            full_s[i]    = (occ_s[i] == FULL_LVL);
            empty_s[i]   = (occ_s[i] == {AWP{1'b0}});
            push_s[i]    = vld_s[i] & ~full_s[i];
            rdata_s[i]   = mem_r[i][rptr_r[i][AW-1:0]];
            occ_nxt_s[i] = occ_s[i] + {{AW{1'b0}}, push_s[i]} - {{AW{1'b0}}, pop_s[i]};
        end
    end

    // Pop decode: only the granted source, only when it has data and downstream is open
    always_comb begin
        pop_s = 2'b00;
        case (state_r)
            ST_SEND0: begin
                if (!empty_s[0] && !Q_BP) begin
                    pop_s = 2'b01;
                end else begin
                    pop_s = 2'b00;
                end
            end
            ST_SEND1: begin
                if (!empty_s[1] && !Q_BP) begin
                    pop_s = 2'b10;
                end else begin
                    pop_s = 2'b00;
                end
            end
            default: pop_s = 2'b00;
        endcase
    end

    // Head word of the granted FIFO
    always_comb begin
        if (state_r == ST_SEND1) begin
            cur_word_s = rdata_s[1];
        end else begin
            cur_word_s = rdata_s[0];
        end
    end

    // FIFO pointers, storage, registered backpressure and sticky overflow
    always_ff @(posedge CLK) begin
        if (SYS_RST) begin
            for (int i = 0; i < 2; i++) begin
                wptr_r[i] <= {AWP{1'b0}};
                rptr_r[i] <= {AWP{1'b0}};
            end
            bp_r  <= 2'b00;
            ovf_r <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push_s[i]) begin
                    mem_r[i][wptr_r[i][AW-1:0]] <= din_s[i];
                    wptr_r[i] <= wptr_r[i] + {{AW{1'b0}}, 1'b1};
                end
                if (pop_s[i]) begin
                    rptr_r[i] <= rptr_r[i] + {{AW{1'b0}}, 1'b1};
                end
                bp_r[i] <= (occ_nxt_s[i] >= BP_LVL);
                if (vld_s[i] && full_s[i]) begin
                    ovf_r[i] <= 1'b1;
                end
            end
        end
    end

    // Packet FSM: round-robin grant in IDLE, header/payload tracking and registered output
    always_ff @(posedge CLK) begin
        if (SYS_RST) begin
            state_r    <= ST_IDLE;
            last_r     <= 1'b1;
            hdr_done_r <= 1'b0;
            rem_r      <= {LEN_W{1'b0}};
            q_r        <= 64'd0;
            q_valid_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    q_valid_r <= 1'b0;
                    // On a tie the source that did not win last time is granted
                    if (!empty_s[0] && !empty_s[1]) begin
                        state_r <= last_r ? ST_SEND0 : ST_SEND1;
                        last_r  <= ~last_r;
                        busy_r  <= 1'b1;
                    end else if (!empty_s[0]) begin
                        state_r <= ST_SEND0;
                        last_r  <= 1'b0;
                        busy_r  <= 1'b1;
                    end else if (!empty_s[1]) begin
                        state_r <= ST_SEND1;
                        last_r  <= 1'b1;
                        busy_r  <= 1'b1;
                    end
                end
                ST_SEND0, ST_SEND1: begin
                    if (pop_s != 2'b00) begin
                        q_r       <= cur_word_s;
                        q_valid_r <= 1'b1;
                        if (!hdr_done_r) begin
                            rem_r <= cur_word_s[LEN_W-1:0];
                            if (cur_word_s[LEN_W-1:0] == {LEN_W{1'b0}}) begin
                                state_r <= ST_IDLE;
                                busy_r  <= 1'b0;
                            end else begin
                                hdr_done_r <= 1'b1;
                            end
                        end else begin
                            rem_r <= rem_r - LEN_W'(1);
                            if (rem_r == LEN_W'(1)) begin
                                state_r    <= ST_IDLE;
                                busy_r     <= 1'b0;
                                hdr_done_r <= 1'b0;
                            end
                        end
                    end else begin
                        // Stall (empty FIFO or downstream busy): Q holds its value
                        q_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    hdr_done_r <= 1'b0;
                    q_valid_r  <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_out_arb.sv
module tb_pe_out_arb;

    logic        CLK;
    logic        SYS_RST;
    logic [63:0] S0_D;
    logic        S0_VALID;
    logic        S0_BP;
    logic [63:0] S1_D;
    logic        S1_VALID;
    logic        S1_BP;
    logic [63:0] Q;
    logic        Q_VALID;
    logic        Q_BP;
    logic        BUSY;
    logic [1:0]  OVF;

    pe_out_arb #(.FDEPTH(16), .BP_SLACK(4), .LEN_W(16)) dut (
        .CLK      (CLK),
        .SYS_RST  (SYS_RST),
        .S0_D     (S0_D),
        .S0_VALID (S0_VALID),
        .S0_BP    (S0_BP),
        .S1_D     (S1_D),
        .S1_VALID (S1_VALID),
        .S1_BP    (S1_BP),
        .Q        (Q),
        .Q_VALID  (Q_VALID),
        .Q_BP     (Q_BP),
        .BUSY     (BUSY),
        .OVF      (OVF)
    );

    int          n_cmp;
    int          n_err;
    int          busy_cnt;
    logic [63:0] exp_q [$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every valid output word, checks Q_BP blocking
    initial begin : monitor
        logic        bp_last;
        logic [63:0] e;
        bp_last = 1'b0;
        forever begin
            @(negedge CLK);
            if (BUSY) busy_cnt++;
            if (bp_last) check("qbp_blocks_valid", {63'd0, Q_VALID}, 64'd0);
            if (Q_VALID) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got %h, expected no output", Q);
                end else begin
                    e = exp_q.pop_front();
                    check("q_data", Q, e);
                end
            end
            bp_last = Q_BP;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push0(input logic [63:0] d);
        S0_D = d; S0_VALID = 1'b1;
        step();
        S0_VALID = 1'b0;
    endtask

    task automatic push1(input logic [63:0] d);
        S1_D = d; S1_VALID = 1'b1;
        step();
        S1_VALID = 1'b0;
    endtask

    task automatic push2(input logic [63:0] d0, input logic [63:0] d1);
        S0_D = d0; S0_VALID = 1'b1;
        S1_D = d1; S1_VALID = 1'b1;
        step();
        S0_VALID = 1'b0;
        S1_VALID = 1'b0;
    endtask

    task automatic do_reset();
        SYS_RST = 1'b1;
        step();
        exp_q.delete();
        SYS_RST = 1'b0;
    endtask

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || BUSY) && cyc < 300) begin
            step();
            cyc++;
        end
        if (cyc >= 300) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got %0d words outstanding, expected 0", name, exp_q.size());
        end
        repeat (4) step();
    endtask

    initial begin : stim
        logic [63:0] h0, h1, w;
        n_cmp = 0; n_err = 0; busy_cnt = 0;
        SYS_RST = 1'b1; S0_D = 64'd0; S0_VALID = 1'b0; S1_D = 64'd0; S1_VALID = 1'b0; Q_BP = 1'b0;
        repeat (2) step();
        check("rst_q_valid", {63'd0, Q_VALID}, 64'd0);
        check("rst_q", Q, 64'd0);
        check("rst_busy", {63'd0, BUSY}, 64'd0);
        check("rst_s0_bp", {63'd0, S0_BP}, 64'd0);
        check("rst_s1_bp", {63'd0, S1_BP}, 64'd0);
        check("rst_ovf", {62'd0, OVF}, 64'd0);
        SYS_RST = 1'b0;
        step();

        // Single packet, LEN=2, latency and BUSY duration
        h0 = {48'hAAAA_0000_0001, 16'd2};
        exp_q.push_back(h0); exp_q.push_back(64'hA1); exp_q.push_back(64'hA2);
        busy_cnt = 0;
        push0(h0);
        check("single_qv_t0", {63'd0, Q_VALID}, 64'd0);
        check("single_busy_t0", {63'd0, BUSY}, 64'd0);
        push0(64'hA1);
        check("single_busy_t1", {63'd0, BUSY}, 64'd1);
        check("single_qv_t1", {63'd0, Q_VALID}, 64'd0);
        push0(64'hA2);
        check("single_qv_t2", {63'd0, Q_VALID}, 64'd1);
        check("single_q_t2", Q, h0);
        drain("single");
        check("single_busy_cycles", 64'(busy_cnt), 64'd3);

        // Contention after reset: S0 first, then S1; repeated -> S0 first again
        do_reset();
        for (int r = 0; r < 2; r++) begin
            h0 = {32'hC000_0000, 16'(r), 16'd1};
            h1 = {32'hC111_1111, 16'(r), 16'd1};
            exp_q.push_back(h0); exp_q.push_back(64'hC0D0 + 64'(r));
            exp_q.push_back(h1); exp_q.push_back(64'hC1D0 + 64'(r));
            push2(h0, h1);
            push2(64'hC0D0 + 64'(r), 64'hC1D0 + 64'(r));
            drain("contention");
        end

        // Backpressure for 5 cycles in the middle of a LEN=3 S0 packet, S1 waiting
        h0 = {48'hB000_0000_0000, 16'd3};
        h1 = {48'hB111_0000_0000, 16'd0};
        exp_q.push_back(h0); exp_q.push_back(64'hB1); exp_q.push_back(64'hB2);
        exp_q.push_back(64'hB3); exp_q.push_back(h1);
        push0(h0);
        push2(64'hB1, h1);
        push0(64'hB2);
        push0(64'hB3);
        Q_BP = 1'b1;
        repeat (5) step();
        check("bp_busy_held", {63'd0, BUSY}, 64'd1);
        Q_BP = 1'b0;
        drain("backpressure");

        // Input stall inside an S1 packet while S0 has a ready packet
        h1 = {48'hD111_0000_0000, 16'd4};
        h0 = {48'hD000_0000_0000, 16'd0};
        exp_q.push_back(h1); exp_q.push_back(64'hD1); exp_q.push_back(64'hD2);
        exp_q.push_back(64'hD3); exp_q.push_back(64'hD4); exp_q.push_back(h0);
        push1(h1);
        push1(64'hD1);
        push1(64'hD2);
        push0(h0);
        repeat (5) step();
        check("stall_busy", {63'd0, BUSY}, 64'd1);
        check("stall_no_switch_qv", {63'd0, Q_VALID}, 64'd0);
        push1(64'hD3);
        push1(64'hD4);
        drain("stall");

        // Flow control: Q_BP held, 20 words into a 16-deep FIFO
        do_reset();
        Q_BP = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 0) w = {48'hF0F0_0000_0000, 16'd15};
            else        w = {32'hF000_0000, 32'(i)};
            if (i < 16) exp_q.push_back(w);
            push0(w);
            if (i == 10) check("bp_at_11", {63'd0, S0_BP}, 64'd0);
            if (i == 11) check("bp_at_12", {63'd0, S0_BP}, 64'd1);
            if (i == 15) check("ovf_at_16", {62'd0, OVF}, 64'd0);
            if (i == 16) check("ovf_at_17", {62'd0, OVF}, 64'd1);
        end
        Q_BP = 1'b0;
        drain("flow");
        check("ovf_sticky", {62'd0, OVF}, 64'd1);
        check("bp_released", {63'd0, S0_BP}, 64'd0);

        // Reset in the middle of a LEN=5 packet
        h0 = {48'hE000_0000_0000, 16'd5};
        exp_q.push_back(h0); exp_q.push_back(64'hE1); exp_q.push_back(64'hE2); exp_q.push_back(64'hE3);
        push0(h0);
        push0(64'hE1);
        push0(64'hE2);
        push0(64'hE3);
        check("midrst_pre_q", Q, 64'hE1);
        do_reset();
        check("midrst_qv", {63'd0, Q_VALID}, 64'd0);
        check("midrst_busy", {63'd0, BUSY}, 64'd0);
        check("midrst_s0_bp", {63'd0, S0_BP}, 64'd0);
        check("midrst_s1_bp", {63'd0, S1_BP}, 64'd0);
        check("midrst_ovf", {62'd0, OVF}, 64'd0);
        repeat (6) step();
        h1 = {48'hE111_0000_0000, 16'd1};
        exp_q.push_back(h1); exp_q.push_back(64'hE1E1);
        push1(h1);
        push1(64'hE1E1);
        drain("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
